// File: rtl/pulse_extender_multi.sv
// Multi-channel pulse extender. Each channel turns a rising edge on its input into
// an output pulse whose length and retrigger behaviour are set through a set/ack port.
module pulse_extender_multi #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned CH_BITS       = 2,
    parameter int unsigned WIDTH_BITS    = 8,
    parameter int unsigned DEFAULT_WIDTH = 1
) (
    input  logic                  in_clock,
    input  logic                  in_reset_n,
    input  logic                  in_set,
    input  logic [CH_BITS-1:0]    in_channel,
    input  logic [WIDTH_BITS-1:0] in_value,
    input  logic                  in_mode,
    output logic                  out_ack,
    output logic                  out_err,
    input  logic [CHANNELS-1:0]   in_signal,
    output logic [CHANNELS-1:0]   out_signal,
    output logic                  out_busy
);

    localparam logic [CH_BITS:0]      CH_LIMIT  = (CH_BITS+1)'(CHANNELS);
    localparam logic [WIDTH_BITS-1:0] RST_WIDTH = WIDTH_BITS'(DEFAULT_WIDTH);

    logic [CHANNELS-1:0]   hist_q;
    logic [CHANNELS-1:0]   mode_q, mode_d;
    logic [CHANNELS-1:0]   act_mode_q, act_mode_d;
    logic [CHANNELS-1:0]   trig_c;
    logic [CHANNELS-1:0]   sig_d;
    logic [WIDTH_BITS-1:0] cnt_q   [CHANNELS];
    logic [WIDTH_BITS-1:0] cnt_d   [CHANNELS];
    logic [WIDTH_BITS-1:0] width_q [CHANNELS];
    logic [WIDTH_BITS-1:0] width_d [CHANNELS];
    logic                  set_ok_c;
    logic                  set_bad_c;

    // Next-state: edge detect, counter load/decrement, config write.
    always_comb begin
        set_ok_c   = in_set && ({1'b0, in_channel} < CH_LIMIT);
        set_bad_c  = in_set && !({1'b0, in_channel} < CH_LIMIT);
        trig_c     = in_signal & ~hist_q;
        mode_d     = mode_q;
        act_mode_d = act_mode_q;
        sig_d      = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i]   = cnt_q[i];
            width_d[i] = width_q[i];
            // Trigger loads the old width even if a write lands on the same edge.
            if (trig_c[i] && (width_q[i] != '0) && ((cnt_q[i] == '0) || act_mode_q[i])) begin
                cnt_d[i]      = width_q[i];
                act_mode_d[i] = mode_q[i];
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - WIDTH_BITS'(1);
            end
            sig_d[i] = (cnt_d[i] != '0);
            if (set_ok_c && (in_channel == CH_BITS'(i))) begin
                width_d[i] = in_value;
                mode_d[i]  = in_mode;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            hist_q     <= '0;
            mode_q     <= '0;
            act_mode_q <= '0;
            out_signal <= '0;
            out_busy   <= 1'b0;
            out_ack    <= 1'b0;
            out_err    <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= '0;
                width_q[i] <= RST_WIDTH;
            end
        end else begin
            hist_q     <= in_signal;
            mode_q     <= mode_d;
            act_mode_q <= act_mode_d;
            out_signal <= sig_d;
            out_busy   <= |sig_d;
            out_ack    <= set_ok_c;
            out_err    <= set_bad_c;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= cnt_d[i];
                width_q[i] <= width_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pulse_extender_multi.sv
// Directed bench for pulse_extender_multi: four channels with a 3-bit select so
// that out-of-range channel writes can be exercised.
module tb_pulse_extender_multi;

    logic       in_clock = 1'b0;
    logic       in_reset_n;
    logic       in_set;
    logic [2:0] in_channel;
    logic [7:0] in_value;
    logic       in_mode;
    logic       out_ack;
    logic       out_err;
    logic [3:0] in_signal;
    logic [3:0] out_signal;
    logic       out_busy;

    int checks = 0;
    int errors = 0;

    pulse_extender_multi #(
        .CHANNELS(4), .CH_BITS(3), .WIDTH_BITS(8), .DEFAULT_WIDTH(1)
    ) dut (
        .in_clock(in_clock), .in_reset_n(in_reset_n),
        .in_set(in_set), .in_channel(in_channel), .in_value(in_value), .in_mode(in_mode),
        .out_ack(out_ack), .out_err(out_err),
        .in_signal(in_signal), .out_signal(out_signal), .out_busy(out_busy)
    );

    always #5 in_clock = ~in_clock;

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_cfg(input logic [2:0] ch, input logic [7:0] val, input logic mode);
        in_set = 1'b1; in_channel = ch; in_value = val; in_mode = mode;
        tick();
        in_set = 1'b0;
        chk("cfg_ack", 32'(out_ack), 32'd1);
        chk("cfg_err", 32'(out_err), 32'd0);
    endtask

    // Bit c of stim drives channel ch for cycle c; bit c of exp is its expected output.
    task automatic pulse_seq(input string tag, input int ch, input logic [31:0] stim,
                             input logic [31:0] exp, input int n);
        for (int c = 0; c < n; c++) begin
            in_signal[ch] = stim[c];
            tick();
            chk(tag, 32'(out_signal), 32'(exp[c]) << ch);
            chk({tag, "_busy"}, 32'(out_busy), 32'(exp[c]));
        end
        in_signal[ch] = 1'b0;
    endtask

    initial begin
        in_reset_n = 1'b0; in_set = 1'b0; in_channel = '0; in_value = '0;
        in_mode = 1'b0; in_signal = '0;
        tick(); tick();
        chk("rst_sig",  32'(out_signal), 32'h0);
        chk("rst_busy", 32'(out_busy),   32'h0);
        chk("rst_ack",  32'(out_ack),    32'h0);
        chk("rst_err",  32'(out_err),    32'h0);
        in_reset_n = 1'b1;

        // Default width 1 on every channel.
        pulse_seq("dflt_ch0", 0, 32'b001, 32'b001, 3);
        in_signal = 4'hF;
        tick();
        chk("all_on", 32'(out_signal), 32'hF);
        chk("all_busy", 32'(out_busy), 32'h1);
        in_signal = 4'h0;
        tick();
        chk("all_off", 32'(out_signal), 32'h0);

        // Mode 0: second edge at t=2 ignored, 5-cycle pulse.
        write_cfg(3'd1, 8'd5, 1'b0);
        tick();
        chk("ack_once", 32'(out_ack), 32'h0);
        pulse_seq("m0_ch1", 1, 32'b0000_0101, 32'b0001_1111, 8);

        // Mode 1: edges at t=0 and t=3 give 7 continuous cycles.
        write_cfg(3'd2, 8'd4, 1'b1);
        pulse_seq("m1_ch2", 2, 32'b0_0000_1001, 32'b0_0111_1111, 9);

        // Out-of-range channels rejected, nothing written.
        in_set = 1'b1; in_channel = 3'd4; in_value = 8'd9; in_mode = 1'b1;
        tick();
        chk("bad4_err", 32'(out_err), 32'h1);
        chk("bad4_ack", 32'(out_ack), 32'h0);
        in_channel = 3'd7;
        tick();
        in_set = 1'b0;
        chk("bad7_err", 32'(out_err), 32'h1);
        chk("bad7_ack", 32'(out_ack), 32'h0);
        tick();
        chk("bad_err_clr", 32'(out_err), 32'h0);
        pulse_seq("nochg_ch0", 0, 32'b001, 32'b001, 3);

        // Width 0 disables the channel.
        write_cfg(3'd0, 8'd0, 1'b0);
        pulse_seq("dis_ch0", 0, 32'b0011, 32'b0000, 4);

        // Set/trigger collision on ch3: old width 3 used, new width 10 next time.
        write_cfg(3'd3, 8'd3, 1'b0);
        in_set = 1'b1; in_channel = 3'd3; in_value = 8'd10; in_mode = 1'b0;
        in_signal[3] = 1'b1;
        tick();
        in_set = 1'b0;
        chk("coll_sig", 32'(out_signal), 32'h8);
        chk("coll_ack", 32'(out_ack), 32'h1);
        pulse_seq("coll_tail", 3, 32'b0000, 32'b0011, 4);
        // Held high 20 cycles: exactly one 10-cycle pulse.
        pulse_seq("held_ch3", 3, 32'h000F_FFFF, 32'h0000_03FF, 20);
        tick();
        chk("held_end", 32'(out_signal), 32'h0);

        // Async reset mid-pulse.
        write_cfg(3'd1, 8'd200, 1'b0);
        in_signal[1] = 1'b1;
        tick();
        in_signal[1] = 1'b0;
        chk("long_start", 32'(out_signal), 32'h2);
        for (int c = 1; c < 50; c++) tick();
        chk("long_mid", 32'(out_signal), 32'h2);
        #3;
        in_reset_n = 1'b0;
        #1;
        chk("arst_sig",  32'(out_signal), 32'h0);
        chk("arst_busy", 32'(out_busy),   32'h0);
        tick();
        in_reset_n = 1'b1;
        pulse_seq("post_rst_ch1", 1, 32'b001, 32'b001, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
